// File: rtl/cla64_pipe_adder.sv
// Two-stage pipelined adder built from 16-bit carry-lookahead slices.
// Stage 1 registers per-slice generate/propagate; stage 2 resolves slice carries and sums.
module cla64_pipe_adder #(
    parameter int  NSLICE = 4,
    localparam int W      = 16 * NSLICE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         Gm,
    output logic         Pm
);

    // Group generate of four bits; p holds propagates of bits 3..1 only.
    function automatic logic gen4(input logic [3:0] g, input logic [2:0] p);
        return g[3] | (p[2] & g[2]) | (p[2] & p[1] & g[1]) | (p[2] & p[1] & p[0] & g[0]);
    endfunction

    // Flat carries into bits 0..3 of a four-bit group.
    function automatic logic [3:0] cla4(input logic [2:0] g, input logic [2:0] p, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Slice {G, P} with carry-in 0, using two-level lookahead over four nibbles.
    function automatic logic [1:0] cla16_gp(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] bg;
        logic [15:0] bp;
        logic [3:0]  gg;
        logic [3:0]  gp;
        bg = x & y;
        bp = x ^ y;
        for (int j = 0; j < 4; j++) begin
            gg[j] = gen4(bg[4*j +: 4], bp[4*j+1 +: 3]);
            gp[j] = &bp[4*j +: 4];
        end
        return {gen4(gg, gp[3:1]), &gp};
    endfunction

    // Carries into bits 0..15 of a slice; bit 15 itself never affects them.
    function automatic logic [15:0] cla16_carries(input logic [14:0] x, input logic [14:0] y,
                                                  input logic ci);
        logic [14:0] bg;
        logic [14:0] bp;
        logic [2:0]  gg;
        logic [2:0]  gp;
        logic [3:0]  gc;
        logic [15:0] c;
        bg = x & y;
        bp = x ^ y;
        for (int j = 0; j < 3; j++) begin
            gg[j] = gen4(bg[4*j +: 4], bp[4*j+1 +: 3]);
            gp[j] = &bp[4*j +: 4];
        end
        gc = cla4(gg, gp, ci);
        for (int j = 0; j < 4; j++) begin
            c[4*j +: 4] = cla4(bg[4*j +: 3], bp[4*j +: 3], gc[j]);
        end
        return c;
    endfunction

    logic              adv1;
    logic              adv2;
    logic              accept;

    logic              s1_valid_q;
    logic [W-1:0]      a1_q;
    logic [W-1:0]      b1_q;
    logic              cin1_q;
    logic [NSLICE-1:0] g1_q;
    logic [NSLICE-1:0] p1_q;
    logic [NSLICE-1:0] g_d;
    logic [NSLICE-1:0] p_d;

    logic              s2_valid_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              gm_q;
    logic              pm_q;
    logic [W-1:0]      sum_d;
    logic [NSLICE:0]   slice_c;
    logic              gm_d;
    logic              c_msb;

    assign adv2     = !s2_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1;
    assign accept   = in_valid & adv1;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice_gp
            logic [1:0] gp;
            assign gp      = cla16_gp(a[16*gi +: 16], b[16*gi +: 16]);
            assign g_d[gi] = gp[1];
            assign p_d[gi] = gp[0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            cin1_q     <= 1'b0;
            g1_q       <= '0;
            p1_q       <= '0;
        end else if (adv1) begin
            s1_valid_q <= accept;
            if (accept) begin
                a1_q   <= a;
                b1_q   <= b;
                cin1_q <= cin;
                g1_q   <= g_d;
                p1_q   <= p_d;
            end
        end
    end

    // Every slice carry is a sum of products over g/p, not a chain through earlier carries.
    always_comb begin : g_lookahead
        logic term;
        logic acc;
        slice_c    = '0;
        slice_c[0] = cin1_q;
        gm_d       = 1'b0;
        for (int k = 0; k < NSLICE; k++) begin
            acc = cin1_q;
            for (int m = 0; m <= k; m++) acc = acc & p1_q[m];
            for (int j = 0; j <= k; j++) begin
                term = g1_q[j];
                for (int m = j + 1; m <= k; m++) term = term & p1_q[m];
                acc = acc | term;
            end
            slice_c[k+1] = acc;
        end
        for (int k = 0; k < NSLICE; k++) begin
            term = g1_q[k];
            for (int m = k + 1; m < NSLICE; m++) term = term & p1_q[m];
            gm_d = gm_d | term;
        end
    end

    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice_sum
            logic [15:0] cs;
            assign cs = cla16_carries(a1_q[16*gi +: 15], b1_q[16*gi +: 15], slice_c[gi]);
            assign sum_d[16*gi +: 16] = a1_q[16*gi +: 16] ^ b1_q[16*gi +: 16] ^ cs;
            if (gi == NSLICE - 1) begin : g_msb
                assign c_msb = cs[15];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            gm_q       <= 1'b0;
            pm_q       <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= slice_c[NSLICE];
                ovf_q  <= c_msb ^ slice_c[NSLICE];
                gm_q   <= gm_d;
                pm_q   <= &p1_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign Gm        = gm_q;
    assign Pm        = pm_q;

endmodule

// File: tb/tb_cla64_pipe_adder.sv
// Directed bench for cla64_pipe_adder: reset, latency, carry/overflow vectors,
// backpressure ordering and a short randomized handshake run.
module tb_cla64_pipe_adder;

    localparam int NSLICE = 4;
    localparam int W      = 64;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        gm;
        logic        pm;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         gm;
    logic         pm;

    exp_t        exp_q[$];
    exp_t        cur;
    int          checks   = 0;
    int          failures = 0;
    int          n_out    = 0;

    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic        vc [8];
    exp_t        ve [8];
    logic [0:8]  bp_ordy = 9'b110000111;
    logic [0:8]  bp_rdy  = 9'b110000111;

    always #5 clk = ~clk;

    cla64_pipe_adder #(.NSLICE(NSLICE)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .Gm       (gm),
        .Pm       (pm)
    );

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic ci);
        logic [64:0] full;
        logic [64:0] nocin;
        logic [64:0] low;
        exp_t        e;
        full   = {1'b0, x} + {1'b0, y} + {64'b0, ci};
        nocin  = {1'b0, x} + {1'b0, y};
        low    = {2'b0, x[62:0]} + {2'b0, y[62:0]} + {64'b0, ci};
        e.sum  = full[63:0];
        e.cout = full[64];
        e.ovf  = low[63] ^ full[64];
        e.gm   = nocin[64];
        e.pm   = &(x ^ y);
        return e;
    endfunction

    // Drive one cycle of inputs just after the edge; the beat is taken at the next edge.
    task automatic drive_cycle(input logic v, input logic [63:0] av, input logic [63:0] bv,
                               input logic cv, input logic ordy, input exp_t e,
                               output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = cv;
        out_ready = ordy;
        #1;
        acc = v & in_ready;
        if (acc) exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
            n++;
        end
        check_value(tag, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_out", {63'b0, out_valid}, 64'd0);
            end else begin
                cur = exp_q[0];
                check_value("sum", sum, cur.sum);
                check_value("cout", {63'b0, cout}, {63'b0, cur.cout});
                check_value("ovf", {63'b0, ovf}, {63'b0, cur.ovf});
                check_value("Gm", {63'b0, gm}, {63'b0, cur.gm});
                check_value("Pm", {63'b0, pm}, {63'b0, cur.pm});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    $display("OUT %0d sum=0x%016h cout=%0b ovf=%0b Gm=%0b Pm=%0b",
                             n_out, sum, cout, ovf, gm, pm);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        acc;
        int          bi;
        int          sent;
        int          n;
        int          out_before;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;

        va[0] = 64'h0000_FFFF_FFFF_FFFF; vb[0] = 64'h1; vc[0] = 1'b0;
        ve[0] = '{sum: 64'h0001_0000_0000_0000, cout: 1'b0, ovf: 1'b0, gm: 1'b0, pm: 1'b0};
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0; vc[1] = 1'b1;
        ve[1] = '{sum: 64'h0, cout: 1'b1, ovf: 1'b0, gm: 1'b0, pm: 1'b1};
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1; vc[2] = 1'b0;
        ve[2] = '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1, gm: 1'b0, pm: 1'b0};
        va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000; vc[3] = 1'b0;
        ve[3] = '{sum: 64'h0, cout: 1'b1, ovf: 1'b1, gm: 1'b1, pm: 1'b0};
        va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'hFFFF_FFFF_FFFF_FFFF; vc[4] = 1'b1;
        ve[4] = '{sum: 64'hFFFF_FFFF_FFFF_FFFF, cout: 1'b1, ovf: 1'b0, gm: 1'b1, pm: 1'b0};
        va[5] = 64'h0123_4567_89AB_CDEF; vb[5] = 64'hFEDC_BA98_7654_3210; vc[5] = 1'b0;
        ve[5] = '{sum: 64'hFFFF_FFFF_FFFF_FFFF, cout: 1'b0, ovf: 1'b0, gm: 1'b0, pm: 1'b1};
        va[6] = 64'h0123_4567_89AB_CDEF; vb[6] = 64'hFEDC_BA98_7654_3210; vc[6] = 1'b1;
        ve[6] = '{sum: 64'h0, cout: 1'b1, ovf: 1'b0, gm: 1'b0, pm: 1'b1};
        va[7] = 64'hFFFF_0000_FFFF_0000; vb[7] = 64'h0000_FFFF_0001_0000; vc[7] = 1'b0;
        ve[7] = '{sum: 64'h0, cout: 1'b1, ovf: 1'b0, gm: 1'b1, pm: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_value("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check_value("rst_sum", sum, 64'd0);
        check_value("rst_cout", {63'b0, cout}, 64'd0);
        check_value("rst_ovf", {63'b0, ovf}, 64'd0);
        check_value("rst_Gm", {63'b0, gm}, 64'd0);
        check_value("rst_Pm", {63'b0, pm}, 64'd0);
        rst = 1'b0;
        #1;
        check_value("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Two-cycle latency on a single beat.
        drive_cycle(1'b1, va[0], vb[0], vc[0], 1'b1, ve[0], acc);
        check_value("lat_accept", {63'b0, acc}, 64'd1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        check_value("lat_cycle1_valid", {63'b0, out_valid}, 64'd0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        check_value("lat_cycle2_valid", {63'b0, out_valid}, 64'd1);
        drain("lat_drain");

        // Fill both stages under backpressure, then reset with beats in flight.
        drive_cycle(1'b1, va[1], vb[1], vc[1], 1'b0, ve[1], acc);
        check_value("fill_acc0", {63'b0, acc}, 64'd1);
        drive_cycle(1'b1, va[2], vb[2], vc[2], 1'b0, ve[2], acc);
        check_value("fill_acc1", {63'b0, acc}, 64'd1);
        drive_cycle(1'b1, va[3], vb[3], vc[3], 1'b0, ve[3], acc);
        check_value("full_in_ready", {63'b0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_value("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check_value("midrst_sum", sum, 64'd0);
        check_value("midrst_cout", {63'b0, cout}, 64'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_value("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        out_before = n_out;
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        check_value("midrst_no_output", 64'(n_out), 64'(out_before));
        check_value("midrst_idle_valid", {63'b0, out_valid}, 64'd0);

        // Back-to-back directed vectors at full throughput.
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, va[i], vb[i], vc[i], 1'b1, ve[i], acc);
            check_value($sformatf("stream_acc_%0d", i), {63'b0, acc}, 64'd1);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        drain("stream_drain");
        check_value("stream_count", 64'(n_out), 64'(out_before + 8));

        // Beats i+i with out_ready low for four cycles.
        bi = 1;
        for (int s = 0; s < 9; s++) begin
            drive_cycle(bi <= 5, 64'(bi), 64'(bi), 1'b0, bp_ordy[s],
                        '{sum: 64'(2 * bi), cout: 1'b0, ovf: 1'b0, gm: 1'b0, pm: 1'b0}, acc);
            check_value($sformatf("bp_in_ready_%0d", s), {63'b0, in_ready}, {63'b0, bp_rdy[s]});
            if (acc) bi++;
        end
        check_value("bp_all_sent", 64'(bi), 64'd6);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        drain("bp_drain");

        // Random operands with random valid/ready, against the arithmetic reference.
        sent = 0;
        n    = 0;
        while (sent < 300 && n < 5000) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            rc = 1'($urandom_range(0, 1));
            drive_cycle($urandom_range(0, 3) != 0, ra, rb, rc, $urandom_range(0, 3) != 0,
                        model(ra, rb, rc), acc);
            if (acc) sent++;
            n++;
        end
        check_value("rand_sent", 64'(sent), 64'd300);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, acc);
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
